// File: rtl/mips_pkg.sv
// Shared MIPS definitions: primary opcodes, memory-stage state encoding and
// helpers that map an opcode/address pair onto byte enables and store lanes.
package mips_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic {IDLE, BUS} state_t;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic is_mem_op(input logic [5:0] op);
        return is_load(op) || is_store(op);
    endfunction

    function automatic logic [3:0] byte_enable(input logic [5:0] op, input logic [1:0] lane);
        if (op inside {OP_LB, OP_LBU, OP_SB})
            return 4'b0001 << lane;
        else if (op inside {OP_LH, OP_LHU, OP_SH})
            return lane[1] ? 4'b1100 : 4'b0011;
        else
            return 4'b1111;
    endfunction

    // Narrow stores are replicated so the memory only has to honour the enables.
    function automatic logic [31:0] store_lanes(input logic [5:0] op, input logic [31:0] data);
        if (op == OP_SB)
            return {4{data[7:0]}};
        else if (op == OP_SH)
            return {2{data[15:0]}};
        else
            return data;
    endfunction

    function automatic logic misaligned(input logic [5:0] op, input logic [1:0] lane);
        if (op inside {OP_LH, OP_LHU, OP_SH})
            return lane[0];
        else if (op inside {OP_LW, OP_SW})
            return lane != 2'b00;
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword out of a bus word and sign- or
// zero-extends it according to the load opcode.
module load_align
    import mips_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [5:0]  opcode,
    output logic [31:0] data
);

    logic [7:0]  lanes [4];
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lanes[gi] = rdata[8*gi +: 8];
    end

    assign byte_lane = lanes[addr];
    assign half_lane = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data = rdata;
        case (opcode)
            OP_LB:   data = {{24{byte_lane[7]}}, byte_lane};
            OP_LBU:  data = {24'h0, byte_lane};
            OP_LH:   data = {{16{half_lane[15]}}, half_lane};
            OP_LHU:  data = {16'h0, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: passes ALU results through, runs one data-bus transaction
// per load/store with a cycle-count abort. Define MEM_ALIGN_CHECK_EN to fault misaligned accesses.
module mem_stage
    import mips_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [5:0]  in_opcode,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_store_data,
    input  logic [4:0]  in_write_reg,
    input  logic        in_reg_we,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        wb_we,
    output logic        wb_err
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(BUS_TIMEOUT - 1);

    state_t      state_reg;
    logic [7:0]  count_reg;
    logic [5:0]  op_reg;
    logic [1:0]  lane_reg;
    logic [4:0]  reg_reg;
    logic [31:0] load_data;

    load_align u_load_align (
        .rdata  (dbus_rdata),
        .addr   (lane_reg),
        .opcode (op_reg),
        .data   (load_data)
    );

    assign stall = (state_reg == BUS) && !dbus_ack;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            op_reg     <= '0;
            lane_reg   <= '0;
            reg_reg    <= '0;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_be    <= '0;
            dbus_wdata <= '0;
            wb_valid   <= 1'b0;
            wb_reg     <= '0;
            wb_data    <= '0;
            wb_we      <= 1'b0;
            wb_err     <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        if (!is_mem_op(in_opcode)) begin
                            wb_valid <= 1'b1;
                            wb_reg   <= in_write_reg;
                            wb_data  <= in_addr;
                            wb_we    <= in_reg_we;
                            wb_err   <= 1'b0;
                        end
`ifdef MEM_ALIGN_CHECK_EN
                        else if (misaligned(in_opcode, in_addr[1:0])) begin
                            wb_valid <= 1'b1;
                            wb_reg   <= in_write_reg;
                            wb_we    <= 1'b0;
                            wb_err   <= 1'b1;
                        end
`endif
                        else begin
                            state_reg  <= BUS;
                            count_reg  <= '0;
                            op_reg     <= in_opcode;
                            lane_reg   <= in_addr[1:0];
                            reg_reg    <= in_write_reg;
                            dbus_req   <= 1'b1;
                            dbus_we    <= is_store(in_opcode);
                            dbus_addr  <= {in_addr[31:2], 2'b00};
                            dbus_be    <= byte_enable(in_opcode, in_addr[1:0]);
                            dbus_wdata <= store_lanes(in_opcode, in_store_data);
                        end
                    end
                end
                BUS: begin
                    // Ack is checked before the timeout so a last-cycle ack still completes.
                    if (dbus_ack) begin
                        state_reg <= IDLE;
                        count_reg <= '0;
                        dbus_req  <= 1'b0;
                        wb_valid  <= 1'b1;
                        wb_reg    <= reg_reg;
                        wb_we     <= is_load(op_reg);
                        wb_err    <= 1'b0;
                        if (is_load(op_reg))
                            wb_data <= load_data;
                    end else if (count_reg == TIMEOUT_LAST) begin
                        state_reg <= IDLE;
                        count_reg <= '0;
                        dbus_req  <= 1'b0;
                        wb_valid  <= 1'b1;
                        wb_reg    <= reg_reg;
                        wb_we     <= 1'b0;
                        wb_err    <= 1'b1;
                    end else begin
                        count_reg <= count_reg + 8'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
